// File: rtl/pipeline_hazard_controller_if.sv
// Front-end hazard control bundle: pipeline status in, stall/flush controls and counters out.
// The controller is the slave; the pipeline (or a bench) is the master.
interface pipeline_hazard_controller_if #(
    parameter int XLEN = 32
);
    logic            IM_ready;
    logic [4:0]      ID_rs1;
    logic [4:0]      ID_rs2;
    logic            ID_rs1_used;
    logic            ID_rs2_used;
    logic            EX_mem_read;
    logic [4:0]      EX_rd;
    logic            EX_mispredict;

    logic            pc_stall;
    logic            IF_ID_stall;
    logic            IF_ID_flush;
    logic            ID_EX_flush;
    logic            fetch_discard;
    logic [XLEN-1:0] stall_cycles;
    logic [XLEN-1:0] flush_count;

    modport master (
        output IM_ready, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
               EX_mem_read, EX_rd, EX_mispredict,
        input  pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush,
               fetch_discard, stall_cycles, flush_count
    );

    modport slave (
        input  IM_ready, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
               EX_mem_read, EX_rd, EX_mispredict,
        output pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush,
               fetch_discard, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// RV32I front-end sequencer: load-use stalls, mispredict flushes, fetch-latency bubbles,
// a RUN/DISCARD machine dropping the wrong-path fetch after a redirect, and saturating counters.
module pipeline_hazard_controller #(
    parameter int XLEN = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_hazard_controller_if.slave   hz
);
    typedef enum logic {RUN, DISCARD} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [XLEN-1:0] r_stallCycles;
    logic [XLEN-1:0] r_flushCount;
    logic            w_loadUse;
    logic            w_acceptFlush;
    logic            w_pcStall;
    logic            w_ifIdStall;
    logic            w_ifIdFlush;
    logic            w_idExFlush;
    logic            w_fetchDiscard;

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign w_loadUse = hz.EX_mem_read && (hz.EX_rd != 5'd0) &&
                       ((hz.ID_rs1_used && (hz.ID_rs1 == hz.EX_rd)) ||
                        (hz.ID_rs2_used && (hz.ID_rs2 == hz.EX_rd)));

    assign w_acceptFlush = !reset && (r_state == RUN) && hz.EX_mispredict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (hz.EX_mispredict && !hz.IM_ready) w_nextState = DISCARD;
            DISCARD: if (hz.IM_ready)                      w_nextState = RUN;
            default:                                       w_nextState = RUN;
        endcase
    end

    // Mispredict outranks load-use, which outranks a late fetch; DISCARD ignores EX/ID.
    always_comb begin
        w_pcStall      = 1'b0;
        w_ifIdStall    = 1'b0;
        w_ifIdFlush    = 1'b0;
        w_idExFlush    = 1'b0;
        w_fetchDiscard = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    if (hz.EX_mispredict) begin
                        w_ifIdFlush = 1'b1;
                        w_idExFlush = 1'b1;
                    end else if (w_loadUse) begin
                        w_pcStall   = 1'b1;
                        w_ifIdStall = 1'b1;
                        w_idExFlush = 1'b1;
                    end else if (!hz.IM_ready) begin
                        w_pcStall   = 1'b1;
                        w_ifIdFlush = 1'b1;
                    end
                end
                DISCARD: begin
                    w_pcStall      = 1'b1;
                    w_ifIdFlush    = 1'b1;
                    w_fetchDiscard = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (w_pcStall && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + XLEN'(1);
            end
            if (w_acceptFlush && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + XLEN'(1);
            end
        end
    end

    assign hz.pc_stall      = w_pcStall;
    assign hz.IF_ID_stall   = w_ifIdStall;
    assign hz.IF_ID_flush   = w_ifIdFlush;
    assign hz.ID_EX_flush   = w_idExFlush;
    assign hz.fetch_discard = w_fetchDiscard;
    assign hz.stall_cycles  = r_stallCycles;
    assign hz.flush_count   = r_flushCount;
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequences the front end of the RV32I five-stage pipeline. It generates the PC hold, IF/ID hold, IF/ID flush and ID/EX flush controls from three sources: load-use hazards, EX-stage branch mispredictions, and instruction-memory response latency. A small state machine discards a stale in-flight fetch after a redirect. Saturating counters record stall cycles and flush events. The block sits beside the PC, IF_ID_Register and ID_EX register and drives their stall/flush inputs.

## Interface
- XLEN, 32, width of the performance counters
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- IM_ready  in  1  instruction memory response valid for the outstanding fetch this cycle
- ID_rs1  in  5  rs1 field of instruction in ID
- ID_rs2  in  5  rs2 field of instruction in ID
- ID_rs1_used  in  1  ID instruction reads rs1
- ID_rs2_used  in  1  ID instruction reads rs2
- EX_mem_read  in  1  instruction in EX is a load
- EX_rd  in  5  destination register of instruction in EX
- EX_mispredict  in  1  branch/jump in EX resolved against the ID-time estimation; PC takes the redirect target this edge
- pc_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF/ID contents
- IF_ID_flush  out  1  load NOP (0x00000013), zero PC fields and branch_estimation into IF/ID
- ID_EX_flush  out  1  load bubble into ID/EX
- fetch_discard  out  1  high while in DISCARD
- stall_cycles  out  XLEN  count of cycles with pc_stall=1
- flush_count  out  XLEN  count of accepted mispredict flushes

## Operation
- States: RUN, DISCARD. Reset enters RUN.
- load_use = EX_mem_read && EX_rd!=0 && ((ID_rs1_used && ID_rs1==EX_rd) || (ID_rs2_used && ID_rs2==EX_rd)).
- RUN, priority order:
  - EX_mispredict=1: IF_ID_flush=1, ID_EX_flush=1, pc_stall=0, IF_ID_stall=0; flush_count+1.
    - If IM_ready=0, the outstanding fetch belongs to the wrong path; next state is DISCARD.
    - Otherwise next state is RUN.
  - load_use=1: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1, IF_ID_flush=0. Holds regardless of IM_ready.
  - IM_ready=0: pc_stall=1, IF_ID_flush=1 (bubble into ID), IF_ID_stall=0, ID_EX_flush=0.
  - Otherwise all four controls are 0.
- DISCARD:
  - pc_stall=1, IF_ID_flush=1, IF_ID_stall=0, ID_EX_flush=0, fetch_discard=1.
  - The response arriving with IM_ready=1 is dropped, and the state returns to RUN on that edge.
  - The next fetch (redirect target) issues from RUN.
  - EX_mispredict and load_use are ignored, since EX/ID hold bubbles.
- IF_ID_stall and IF_ID_flush are never both 1.
- Counters:
  - stall_cycles increments on every cycle with pc_stall=1 (RUN or DISCARD).
  - flush_count increments only on an accepted mispredict.
  - Both saturate at all-ones with no wrap.

## Timing
- All control outputs are combinational from the current state and current inputs, valid the same cycle and consumed on the next rising edge. Zero-cycle latency.
- State and counters update on the rising edge only.
- While reset=1, all control outputs and fetch_discard are 0.
- On the reset edge: state=RUN, stall_cycles=0, flush_count=0. Reset mid-DISCARD returns to RUN, and the pending response is not dropped.
- A load-use stall lasts exactly one cycle. The following cycle the load has left EX, so load_use=0.
- Mispredict with IM_ready=1 costs 2 bubbles (IF/ID + ID/EX). With IM_ready=0 it costs 2 plus the number of DISCARD cycles.
- If mispredict and load_use occur simultaneously, the mispredict wins: no stall, and stall_cycles is unchanged.
- rd=x0 never causes a hazard.

## Test plan
- After reset with IM_ready=1 and no hazard: all controls 0, counters 0, fetch_discard=0.
- EX_mem_read=1, EX_rd=5, ID_rs2=5, ID_rs2_used=1 for one cycle -> pc_stall=IF_ID_stall=ID_EX_flush=1 for exactly that cycle, stall_cycles=1. Repeat with EX_rd=0 -> no stall.
- EX_mispredict=1 with IM_ready=1 -> IF_ID_flush=ID_EX_flush=1, pc_stall=0, flush_count=1, state stays RUN.
- EX_mispredict=1 with IM_ready=0, then IM_ready=0 for 2 cycles, then 1 -> DISCARD for 3 cycles with pc_stall=IF_ID_flush=1; the response is dropped and RUN resumes; stall_cycles=3.
- Simultaneous EX_mispredict and load_use -> flush outputs only, IF_ID_stall=0, stall_cycles unchanged.
- Preload stall_cycles near saturation by holding IM_ready=0 (small XLEN=4 instance, 20 cycles) -> stall_cycles holds at 4'hF. Assert reset mid-DISCARD -> RUN, counters 0 next cycle.
